// File: rtl/conv_job_csr.sv
// conv_job_csr: MMIO control/status bank that queues conv jobs in a show-ahead FIFO.
// It issues jobs over valid/ready, counts completions, and raises a level irq on completions or sticky errors.
module conv_job_csr #(
    parameter int          DATA_W = 32,
    parameter int          DEPTH  = 4,
    parameter int          ID_W   = 4,
    parameter logic [31:0] BASE   = 32'h8000_0040
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              job_valid_o,
    input  logic              job_ready_i,
    output logic [DATA_W-1:0] job_fm_dim_o,
    output logic [DATA_W-1:0] job_wt_offset_o,
    output logic [DATA_W-1:0] job_ifm_offset_o,
    output logic [DATA_W-1:0] job_ofm_offset_o,
    output logic [ID_W-1:0]   job_id_o,
    input  logic              acc_done_i,
    output logic              busy_o,
    output logic              irq_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] fm_q, wt_q, ifm_q, ofm_q, rdata_q, rd_data;
    logic [DATA_W-1:0] fm_mem [DEPTH];
    logic [DATA_W-1:0] wt_mem [DEPTH];
    logic [DATA_W-1:0] ifm_mem [DEPTH];
    logic [DATA_W-1:0] ofm_mem [DEPTH];
    logic [ID_W-1:0]   id_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        inflight_q, inflight_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic              valid_q, irq_en_q, ovf_q, ovf_d, spur_q, spur_d;
    logic [31:0]       off, status;
    logic [2:0]        sel;
    logic              hit, wr, start, clr, dclr, full, empty, push, pop, done_ok;

    assign off   = addr_i - BASE;
    assign hit   = (off < 32'd32) && (off[1:0] == 2'b00);
    assign sel   = off[4:2];
    assign wr    = wr_en_i & hit;
    assign start = wr && sel == 3'd4 && wdata_i[0];
    assign clr   = wr && sel == 3'd4 && wdata_i[1];
    assign dclr  = wr && sel == 3'd7;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    // Full is judged before any same-cycle pop, so a start into a full queue is always dropped
    assign push  = start & ~full;
    assign pop   = valid_q & job_ready_i;
    assign done_ok = acc_done_i && (inflight_q + 8'(pop)) != 8'd0;

    always_comb begin
        count_d    = count_q + CW'(push) - CW'(pop);
        inflight_d = inflight_q + 8'(pop) - 8'(done_ok);
        ovf_d      = (ovf_q & ~clr) | (start & full);
        spur_d     = (spur_q & ~clr) | (acc_done_i & ~done_ok);
        next_id_d  = next_id_q + ID_W'(push);
        done_cnt_d = dclr ? 16'(done_ok) :
                     (done_ok && done_cnt_q != 16'hFFFF) ? done_cnt_q + 16'd1 : done_cnt_q;
    end

    assign status = {8'h00, inflight_q, 8'(count_q), 3'b000, spur_q, ovf_q, busy_o, full, empty};

    always_comb begin
        rd_data = '0;
        if (hit)
            case (sel)
                3'd0:    rd_data = fm_q;
                3'd1:    rd_data = wt_q;
                3'd2:    rd_data = ifm_q;
                3'd3:    rd_data = ofm_q;
                3'd5:    rd_data = DATA_W'(status);
                3'd6:    rd_data = DATA_W'(irq_en_q);
                3'd7:    rd_data = DATA_W'(done_cnt_q);
                default: rd_data = '0;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fm_q       <= '0;
            wt_q       <= '0;
            ifm_q      <= '0;
            ofm_q      <= '0;
            rdata_q    <= '0;
            irq_en_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            inflight_q <= '0;
            done_cnt_q <= '0;
            next_id_q  <= '0;
            ovf_q      <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            if (wr && sel == 3'd0) fm_q <= wdata_i;
            if (wr && sel == 3'd1) wt_q <= wdata_i;
            if (wr && sel == 3'd2) ifm_q <= wdata_i;
            if (wr && sel == 3'd3) ofm_q <= wdata_i;
            if (wr && sel == 3'd6) irq_en_q <= wdata_i[0];
            if (rd_en_i) rdata_q <= rd_data;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            valid_q    <= count_d != '0;
            inflight_q <= inflight_d;
            done_cnt_q <= done_cnt_d;
            next_id_q  <= next_id_d;
            ovf_q      <= ovf_d;
            spur_q     <= spur_d;
        end

    always_ff @(posedge clk)
        if (push) begin
            fm_mem[wr_ptr_q]  <= fm_q;
            wt_mem[wr_ptr_q]  <= wt_q;
            ifm_mem[wr_ptr_q] <= ifm_q;
            ofm_mem[wr_ptr_q] <= ofm_q;
            id_mem[wr_ptr_q]  <= next_id_q;
        end

    // Head fields are gated so that the uninitialised storage never leaks out after reset
    assign job_valid_o      = valid_q;
    assign job_fm_dim_o     = valid_q ? fm_mem[rd_ptr_q] : '0;
    assign job_wt_offset_o  = valid_q ? wt_mem[rd_ptr_q] : '0;
    assign job_ifm_offset_o = valid_q ? ifm_mem[rd_ptr_q] : '0;
    assign job_ofm_offset_o = valid_q ? ofm_mem[rd_ptr_q] : '0;
    assign job_id_o         = valid_q ? id_mem[rd_ptr_q] : '0;
    assign rdata_o          = rdata_q;
    assign busy_o           = valid_q | (inflight_q != 8'd0);
    assign irq_o            = irq_en_q & ((done_cnt_q != 16'd0) | ovf_q | spur_q);
endmodule

// File: tb/tb_conv_job_csr.sv
// tb_conv_job_csr: directed, self-checking bench for the conv job CSR bank and its job queue.
module tb_conv_job_csr;
    localparam logic [31:0] BASE = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, job_ready = 1'b0, acc_done = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        job_valid, busy, irq;
    logic [31:0] fm, wt, ifm, ofm;
    logic [3:0]  job_id;
    int          n_checks = 0, n_fail = 0;

    conv_job_csr dut (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .job_valid_o(job_valid), .job_ready_i(job_ready),
        .job_fm_dim_o(fm), .job_wt_offset_o(wt), .job_ifm_offset_o(ifm), .job_ofm_offset_o(ofm),
        .job_id_o(job_id), .acc_done_i(acc_done), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] o, input logic [31:0] d);
        wr_en = 1'b1; addr = BASE + o; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] o, output logic [31:0] d);
        rd_en = 1'b1; addr = BASE + o;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; job_ready = 1'b0; acc_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({job_valid, busy, irq} !== 3'b000 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got v=%b b=%b i=%b rdata=%h, expected all 0", job_valid, busy, irq, rdata);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 4), d);
            e = (i == 5) ? 32'h1 : 32'h0;
            n_checks++;
            if (d !== e) begin
                n_fail++; $display("FAIL reset_read_%0h: got %h, expected %h", i * 4, d, e);
            end
        end
    endtask

    task automatic test_single_job();
        logic [31:0] d;
        do_reset();
        wr(32'h00, 32'h20); wr(32'h04, 32'h100); wr(32'h08, 32'h200); wr(32'h0C, 32'h300);
        job_ready = 1'b1;
        wr(32'h10, 32'h1);
        n_checks++;
        if ({job_valid, fm, wt, ifm, ofm, job_id} !== {1'b1, 32'h20, 32'h100, 32'h200, 32'h300, 4'd0}) begin
            n_fail++; $display("FAIL single_head: got v=%b %h %h %h %h id=%0d, expected 1 20 100 200 300 id=0", job_valid, fm, wt, ifm, ofm, job_id);
        end
        tick();
        job_ready = 1'b0;
        n_checks++;
        if ({job_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL single_issued: got v=%b busy=%b, expected v=0 busy=1", job_valid, busy);
        end
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0001_0005) begin
            n_fail++; $display("FAIL single_status: got %h, expected 00010005", d);
        end
        acc_done = 1'b1; tick(); acc_done = 1'b0;
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1 || busy !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got cnt=%h busy=%b irq=%b, expected 1 0 0", d, busy, irq);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wr(32'h00, 32'(k));
            wr(32'h10, 32'h1);
        end
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0000_040E || irq !== 1'b0) begin
            n_fail++; $display("FAIL ovf_status: got %h irq=%b, expected 0000040e irq=0", d, irq);
        end
        wr(32'h10, 32'h2);
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0000_0406) begin
            n_fail++; $display("FAIL ovf_clear: got %h, expected 00000406", d);
        end
        job_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({job_valid, job_id, fm} !== {1'b1, 4'(k), 32'(k)}) begin
                n_fail++; $display("FAIL ovf_pop_%0d: got v=%b id=%0d fm=%h, expected v=1 id=%0d fm=%h", k, job_valid, job_id, fm, k, k);
            end
            tick();
        end
        job_ready = 1'b0;
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0004_0005 || job_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained: got %h v=%b, expected 00040005 v=0", d, job_valid);
        end
        wr(32'h10, 32'h1);
        n_checks++;
        if ({job_valid, job_id, fm} !== {1'b1, 4'd4, 32'd4}) begin
            n_fail++; $display("FAIL ovf_next_id: got v=%b id=%0d fm=%h, expected v=1 id=4 fm=4", job_valid, job_id, fm);
        end
    endtask

    task automatic test_done_irq();
        logic [31:0] d;
        do_reset();
        wr(32'h18, 32'h1);
        job_ready = 1'b1;
        wr(32'h10, 32'h1);
        tick();
        job_ready = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_idle: got %b, expected 0", irq);
        end
        acc_done = 1'b1; tick(); acc_done = 1'b0;
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            n_fail++; $display("FAIL done_irq: got cnt=%h irq=%b, expected 1 1", d, irq);
        end
        job_ready = 1'b1;
        wr(32'h10, 32'h1);
        tick();
        job_ready = 1'b0;
        wr_en = 1'b1; addr = BASE + 32'h1C; wdata = '0; acc_done = 1'b1;
        tick();
        wr_en = 1'b0; acc_done = 1'b0;
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL clear_with_done: got %h, expected 1", d);
        end
        wr(32'h1C, 32'h0);
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL done_clear: got cnt=%h irq=%b, expected 0 0", d, irq);
        end
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        do_reset();
        wr(32'h18, 32'h1);
        acc_done = 1'b1; tick(); acc_done = 1'b0;
        rd(32'h1C, d);
        n_checks++;
        if (d !== 32'h0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL spur_count: got cnt=%h irq=%b, expected 0 1", d, irq);
        end
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h0000_0011) begin
            n_fail++; $display("FAIL spur_status: got %h, expected 00000011", d);
        end
        wr(32'h10, 32'h2);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL spur_clear: got irq=%b, expected 0", irq);
        end
    endtask

    task automatic test_rw_map();
        logic [31:0] d;
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; addr = BASE + 32'h04; wdata = 32'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL rw_same_cycle: got %h, expected 0", rdata);
        end
        rd(32'h04, d);
        n_checks++;
        if (d !== 32'h55) begin
            n_fail++; $display("FAIL rw_new_value: got %h, expected 55", d);
        end
        tick();
        n_checks++;
        if (rdata !== 32'h55) begin
            n_fail++; $display("FAIL rdata_hold: got %h, expected 55", rdata);
        end
        wr(32'h20, 32'hFFFF_FFFF);
        wr(32'h10, 32'h0);
        rd(32'h20, d);
        n_checks++;
        if (d !== 32'h0 || job_valid !== 1'b0) begin
            n_fail++; $display("FAIL unmapped: got %h v=%b, expected 0 0", d, job_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        wr(32'h18, 32'h1);
        acc_done = 1'b1; tick(); acc_done = 1'b0;
        for (int k = 0; k < 3; k++) wr(32'h10, 32'h1);
        rd(32'h14, d);
        job_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({job_valid, busy, irq} !== 3'b000 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got v=%b b=%b i=%b rdata=%h, expected all 0", job_valid, busy, irq, rdata);
        end
        job_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd(32'h14, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL post_reset_status: got %h, expected 1", d);
        end
        wr(32'h10, 32'h1);
        n_checks++;
        if ({job_valid, job_id} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL post_reset_id: got v=%b id=%0d, expected v=1 id=0", job_valid, job_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_overflow();
        test_done_irq();
        test_spurious();
        test_rw_map();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
